// File: rtl/branch_resolve_update_pkg.sv
// Shared types and constants for the branch resolve/update block:
// the in-flight tag layout, the 2-bit control-bit encodings and the saturating step.
package branch_resolve_update_pkg;

  localparam int DEFAULT_DEPTH = 4;

  localparam logic [1:0] CB_SNT = 2'b00;
  localparam logic [1:0] CB_WNT = 2'b01;
  localparam logic [1:0] CB_WT  = 2'b10;
  localparam logic [1:0] CB_ST  = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ppc;
    logic [1:0]  cb;
    logic        pc_source;
  } tag_entry_t;

  // Two-bit saturating counter step toward taken or not-taken.
  function automatic logic [1:0] cb_step(input logic [1:0] base, input logic taken);
    if (taken) return (base == CB_ST) ? CB_ST : base + 2'b01;
    else       return (base == CB_SNT) ? CB_SNT : base - 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolve_update_pred_tag_fifo.sv
// In-order FIFO of prediction tags for instructions between fetch and resolve.
// A clear empties it on the same edge and overrides any push or pop.
module pred_tag_fifo
  import branch_resolve_update_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     clear,
  input  logic                     push,
  input  tag_entry_t               push_data,
  input  logic                     pop,
  output tag_entry_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  tag_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Pushes while full are dropped even if a pop frees a slot on the same edge.
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_update.sv
// Resolves in-flight predictions in order: trains the prediction cache and
// raises a one-cycle flush with the corrected PC on a mispredict.
module branch_resolve_update
  import branch_resolve_update_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   F_Valid,
  input  logic [31:0]            F_PC,
  input  logic [33:0]            F_PPC_CB,
  input  logic                   F_PC_Source,
  input  logic                   R_Valid,
  input  logic                   R_IsBranch,
  input  logic                   R_Taken,
  input  logic [31:0]            R_Target,
  output logic                   WE,
  output logic [31:0]            WAddr,
  output logic [31:0]            Data,
  output logic [1:0]             Instr_new_CB,
  output logic                   Flush,
  output logic [31:0]            Redirect_PC,
  output logic                   Full,
  output logic [$clog2(DEPTH):0] Count
);

  tag_entry_t  push_entry;
  tag_entry_t  head;
  logic        pop;
  logic        actual_taken;
  logic [1:0]  base_cb;
  logic        wr_d;
  logic [31:0] data_d;
  logic [1:0]  cb_d;
  logic        mispredict;
  logic [31:0] redirect_d;

  assign push_entry = '{pc: F_PC, ppc: F_PPC_CB[33:2], cb: F_PPC_CB[1:0], pc_source: F_PC_Source};
  assign pop        = R_Valid && (Count != '0);

  pred_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .clear     (pop && mispredict),
    .push      (F_Valid),
    .push_data (push_entry),
    .pop       (R_Valid),
    .head      (head),
    .count     (Count),
    .full      (Full)
  );

  // A not-predicted-taken entry trains from weak not-taken, whatever CB it carried.
  always_comb begin
    actual_taken = R_IsBranch && R_Taken;
    base_cb      = head.pc_source ? head.cb : CB_WNT;
    wr_d         = 1'b0;
    data_d       = R_Target;
    cb_d         = CB_SNT;
    if (R_IsBranch) begin
      wr_d = R_Taken || head.pc_source;
      cb_d = cb_step(base_cb, R_Taken);
    end else if (head.pc_source) begin
      wr_d   = 1'b1;
      data_d = head.ppc;
    end
    mispredict = (head.pc_source != actual_taken) ||
                 (head.pc_source && actual_taken && (head.ppc != R_Target));
    redirect_d = actual_taken ? R_Target : head.pc + 32'd4;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      WE           <= 1'b0;
      WAddr        <= '0;
      Data         <= '0;
      Instr_new_CB <= CB_SNT;
      Flush        <= 1'b0;
      Redirect_PC  <= '0;
    end else begin
      WE    <= pop && wr_d;
      Flush <= pop && mispredict;
      if (pop && wr_d) begin
        WAddr        <= head.pc;
        Data         <= data_d;
        Instr_new_CB <= cb_d;
      end
      if (pop && mispredict) Redirect_PC <= redirect_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_update.sv
// Randomized and directed checks of branch_resolve_update against a queue-based model.
module tb_branch_resolve_update;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        F_Valid;
  logic [31:0] F_PC;
  logic [33:0] F_PPC_CB;
  logic        F_PC_Source;
  logic        R_Valid;
  logic        R_IsBranch;
  logic        R_Taken;
  logic [31:0] R_Target;
  logic        WE;
  logic [31:0] WAddr;
  logic [31:0] Data;
  logic [1:0]  Instr_new_CB;
  logic        Flush;
  logic [31:0] Redirect_PC;
  logic        Full;
  logic [2:0]  Count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ppc;
    int          cb;
    logic        src;
  } mtag_t;

  mtag_t       mq[$];
  logic        m_we;
  logic [31:0] m_waddr;
  logic [31:0] m_data;
  logic [1:0]  m_cb;
  logic        m_flush;
  logic [31:0] m_redir;

  branch_resolve_update #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .F_Valid(F_Valid), .F_PC(F_PC), .F_PPC_CB(F_PPC_CB),
    .F_PC_Source(F_PC_Source), .R_Valid(R_Valid), .R_IsBranch(R_IsBranch),
    .R_Taken(R_Taken), .R_Target(R_Target), .WE(WE), .WAddr(WAddr), .Data(Data),
    .Instr_new_CB(Instr_new_CB), .Flush(Flush), .Redirect_PC(Redirect_PC),
    .Full(Full), .Count(Count)
  );

  always #5 Clk = ~Clk;

  // Reference behaviour of one clock edge, written from the prediction rules.
  task automatic model_edge(input logic rst, input logic fv, input logic [31:0] pc,
                            input logic [31:0] ppc, input logic [1:0] cb, input logic src,
                            input logic rv, input logic br, input logic tk,
                            input logic [31:0] tgt);
    bit    push_ok;
    mtag_t e;
    int    base;
    int    nb;
    bit    taken;
    bit    mis;
    if (rst) begin
      mq.delete();
      m_we = 0; m_flush = 0; m_waddr = 0; m_data = 0; m_cb = 0; m_redir = 0;
      return;
    end
    m_we    = 0;
    m_flush = 0;
    push_ok = fv && (mq.size() < DEPTH);
    if (rv && mq.size() > 0) begin
      e     = mq.pop_front();
      taken = br && tk;
      base  = e.src ? e.cb : 1;
      if (br) begin
        nb = tk ? ((base + 1 > 3) ? 3 : base + 1) : ((base - 1 < 0) ? 0 : base - 1);
        if (tk || e.src) begin
          m_we = 1; m_waddr = e.pc; m_data = tgt; m_cb = 2'(nb);
        end
      end else if (e.src) begin
        m_we = 1; m_waddr = e.pc; m_data = e.ppc; m_cb = 2'b00;
      end
      mis = (e.src != taken) || (e.src && taken && e.ppc != tgt);
      if (mis) begin
        m_flush = 1;
        m_redir = taken ? tgt : e.pc + 32'd4;
        mq.delete();
        push_ok = 0;
      end
    end
    if (push_ok) mq.push_back('{pc: pc, ppc: ppc, cb: int'(cb), src: src});
  endtask

  task automatic step(input logic rst, input logic fv, input logic [31:0] pc,
                      input logic [31:0] ppc, input logic [1:0] cb, input logic src,
                      input logic rv, input logic br, input logic tk,
                      input logic [31:0] tgt);
    Rst = rst; F_Valid = fv; F_PC = pc; F_PPC_CB = {ppc, cb}; F_PC_Source = src;
    R_Valid = rv; R_IsBranch = br; R_Taken = tk; R_Target = tgt;
    @(posedge Clk);
    model_edge(rst, fv, pc, ppc, cb, src, rv, br, tk, tgt);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_tag(input logic [31:0] pc, input logic [31:0] ppc,
                          input logic [1:0] cb, input logic src);
    step(0, 1, pc, ppc, cb, src, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 1, 32'h40, 32'h80, 2'b11, 1, 1, 1, 1, 32'h80);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({WE, Flush, Full, Count, WAddr, Data, Redirect_PC, Instr_new_CB} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state: WE=%b Flush=%b Full=%b Count=%0d WAddr=%h Data=%h Redir=%h CB=%b, required all zero",
               WE, Flush, Full, Count, WAddr, Data, Redirect_PC, Instr_new_CB);
    end
  endtask

  task automatic test_not_predicted_taken();
    push_tag(32'h100, 32'h0, 2'b00, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h200);
    checks++;
    if ({WE, WAddr, Data, Instr_new_CB, Flush, Redirect_PC} !== {1'b1, 32'h100, 32'h200, 2'b10, 1'b1, 32'h200}) begin
      failures++;
      $display("[TB] FAIL npt_taken: WE=%b WAddr=%h Data=%h CB=%b Flush=%b Redir=%h, required 1 100 200 10 1 200",
               WE, WAddr, Data, Instr_new_CB, Flush, Redirect_PC);
    end
    idle();
    checks++;
    if ({WE, Flush, Redirect_PC} !== {1'b0, 1'b0, 32'h200}) begin
      failures++;
      $display("[TB] FAIL pulse_width: WE=%b Flush=%b Redir=%h, required 0 0 200", WE, Flush, Redirect_PC);
    end
  endtask

  task automatic test_correct_taken();
    push_tag(32'h100, 32'h200, 2'b11, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h200);
    checks++;
    if ({WE, WAddr, Data, Instr_new_CB, Flush} !== {1'b1, 32'h100, 32'h200, 2'b11, 1'b0}) begin
      failures++;
      $display("[TB] FAIL correct_taken: WE=%b WAddr=%h Data=%h CB=%b Flush=%b, required 1 100 200 11 0",
               WE, WAddr, Data, Instr_new_CB, Flush);
    end
  endtask

  task automatic test_taken_mispredict_not_taken();
    push_tag(32'h100, 32'h300, 2'b10, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h300);
    checks++;
    if ({WE, WAddr, Instr_new_CB, Flush, Redirect_PC} !== {1'b1, 32'h100, 2'b01, 1'b1, 32'h104}) begin
      failures++;
      $display("[TB] FAIL taken_not_taken: WE=%b WAddr=%h CB=%b Flush=%b Redir=%h, required 1 100 01 1 104",
               WE, WAddr, Instr_new_CB, Flush, Redirect_PC);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) push_tag(32'h1000 + 32'(i * 4), 32'h0, 2'b00, 0);
    checks++;
    if ({Full, Count} !== {1'b1, 3'd4}) begin
      failures++;
      $display("[TB] FAIL full_after_5: Full=%b Count=%0d, required 1 4", Full, Count);
    end
    step(0, 1, 32'h2000, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if ({Full, Count, WE, Flush} !== {1'b0, 3'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL pop_push_full: Full=%b Count=%0d WE=%b Flush=%b, required 0 3 0 0", Full, Count, WE, Flush);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if ({Count, Flush, WE} !== {3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL empty_pop_ignored: Count=%0d Flush=%b WE=%b, required 0 0 0", Count, Flush, WE);
    end
  endtask

  task automatic test_flush_with_push();
    for (int i = 0; i < 4; i++) push_tag(32'h3000 + 32'(i * 4), 32'h0, 2'b00, 0);
    step(0, 1, 32'h4000, 0, 0, 0, 1, 1, 1, 32'h5000);
    checks++;
    if ({Count, Flush, Redirect_PC} !== {3'd0, 1'b1, 32'h5000}) begin
      failures++;
      $display("[TB] FAIL flush_clears: Count=%0d Flush=%b Redir=%h, required 0 1 5000", Count, Flush, Redirect_PC);
    end
  endtask

  task automatic test_reset_pending();
    push_tag(32'h600, 32'h0, 2'b00, 0);
    step(1, 1, 32'h700, 0, 0, 0, 1, 1, 1, 32'h800);
    checks++;
    if ({Flush, WE, Count} !== {1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("[TB] FAIL reset_overrides: Flush=%b WE=%b Count=%0d, required 0 0 0", Flush, WE, Count);
    end
  endtask

  task automatic test_random();
    logic        fv, src, rv, br, tk, rst;
    logic [31:0] pc, ppc, tgt;
    logic [1:0]  cb;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      fv  = ($urandom_range(0, 9) < 6);
      rv  = ($urandom_range(0, 9) < 5);
      br  = ($urandom_range(0, 3) != 0);
      tk  = br && $urandom_range(0, 1);
      src = $urandom_range(0, 1);
      cb  = 2'($urandom_range(0, 3));
      pc  = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      ppc = 32'($urandom_range(0, 15) * 16);
      tgt = 32'($urandom_range(0, 15) * 16);
      if (mq.size() > 0 && $urandom_range(0, 1)) tgt = mq[0].ppc;
      step(rst, fv, pc, ppc, cb, src, rv, br, tk, tgt);
      checks++;
      if ({WE, Flush, Redirect_PC, Count, Full} !== {m_we, m_flush, m_redir, 3'(mq.size()), mq.size() == DEPTH}) begin
        failures++;
        $display("[TB] FAIL rand_ctrl[%0d]: WE=%b Flush=%b Redir=%h Count=%0d Full=%b, required %b %b %h %0d %b",
                 n, WE, Flush, Redirect_PC, Count, Full, m_we, m_flush, m_redir, mq.size(), mq.size() == DEPTH);
      end
      if (m_we) begin
        checks++;
        if ({WAddr, Data, Instr_new_CB} !== {m_waddr, m_data, m_cb}) begin
          failures++;
          $display("[TB] FAIL rand_write[%0d]: WAddr=%h Data=%h CB=%b, required %h %h %b",
                   n, WAddr, Data, Instr_new_CB, m_waddr, m_data, m_cb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_not_predicted_taken();
    test_correct_taken();
    test_taken_mispredict_not_taken();
    test_full();
    test_flush_with_push();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_update.md
BRANCH_RESOLVE_UPDATE -- requirements
Module: branch_resolve_update

Interface
REQ-001 Parameter DEPTH, default 4, in-flight prediction tag capacity (power of two, 2..16).
REQ-002 Clk  in  1  clock; all state on rising edge.
REQ-003 Rst  in  1  reset, synchronous, active-high.
REQ-004 F_Valid  in  1  fetch issued an instruction this cycle.
REQ-005 F_PC  in  32  address of fetched instruction.
REQ-006 F_PPC_CB  in  34  prediction-cache {PPC[31:0], CB[1:0]} for F_PC.
REQ-007 F_PC_Source  in  1  prediction-cache taken prediction for F_PC.
REQ-008 R_Valid  in  1  oldest in-flight instruction resolved this cycle (in order).
REQ-009 R_IsBranch  in  1  resolved instruction is a branch/jump.
REQ-010 R_Taken  in  1  actual branch direction.
REQ-011 R_Target  in  32  actual branch target.
REQ-012 WE  out  1  prediction-cache write enable.
REQ-013 WAddr  out  32  prediction-cache write address.
REQ-014 Data  out  32  prediction-cache target to write.
REQ-015 Instr_new_CB  out  2  prediction-cache new control bits.
REQ-016 Flush  out  1  mispredict pulse; fetch discards wrong-path work.
REQ-017 Redirect_PC  out  32  correct next PC, valid while Flush=1.
REQ-018 Full  out  1  tag queue full; fetch stalls.
REQ-019 Count  out  $clog2(DEPTH)+1  tag queue occupancy.

Function
REQ-020 Tag queue: FIFO of {F_PC, PPC, CB, PC_Source}; push when F_Valid && !Full; F_Valid while Full ignored (no bypass, even with same-cycle pop).
REQ-021 Pop on R_Valid when Count>0; R_Valid with Count=0 ignored, no outputs change.
REQ-022 Full = (Count==DEPTH), combinational from Count; simultaneous push+pop keeps Count unchanged; pointers wrap modulo DEPTH.
REQ-023 Base state: head PC_Source=1 -> head CB; PC_Source=0 -> 2'b01 (weak not-taken), regardless of stored CB.
REQ-024 Update, branch: taken -> base+1 saturating at 2'b11; not-taken -> base-1 saturating at 2'b00.
REQ-025 Write: WE=1 one cycle after pop of a branch, WAddr=head PC, Data=R_Target, Instr_new_CB=updated CB; suppressed when not-taken and PC_Source=0.
REQ-026 Non-branch with PC_Source=1 (alias): write WAddr=head PC, Data=head PPC, Instr_new_CB=2'b00.
REQ-027 Mispredict: PC_Source!=(R_IsBranch&&R_Taken), or PC_Source=1 && R_Taken && PPC!=R_Target.
REQ-028 On mispredict: Flush=1 and Redirect_PC = taken ? R_Target : head PC+4 (mod 2^32), both registered, one cycle after pop; Flush one cycle wide.
REQ-029 Same edge that registers Flush empties the queue (Count=0); any push on that edge discarded.
REQ-030 WE/WAddr/Data/Instr_new_CB registered, single-cycle pulse; Redirect_PC holds last value when Flush=0.

Reset
REQ-031 Rst=1: queue empty, pointers 0, Count=0, Full=0, WE=0, Flush=0, WAddr/Data/Redirect_PC=0, Instr_new_CB=2'b00.
REQ-032 Rst overrides same-cycle push, pop and pending write/flush; in-flight tags are lost.

Structure
REQ-033 Shared package: tag entry typedef, CB constants (SNT=00, WNT=01, WT=10, ST=11), DEFAULT_DEPTH=4.
REQ-034 Single sub-module pred_tag_fifo (parameterised depth, clear input, count/full outputs); update/flush logic in top.

Verification
REQ-035 Push F_PC=0x100, PC_Source=0; resolve branch taken, target 0x200 -> next cycle WE=1, WAddr=0x100, Data=0x200, CB=10, Flush=1, Redirect_PC=0x200.
REQ-036 Push 0x100 with PC_Source=1, CB=11, PPC=0x200; resolve taken 0x200 -> WE=1 CB=11, Flush=0.
REQ-037 Push 0x100 PC_Source=1 CB=10; resolve not-taken -> WE=1 CB=01, Flush=1, Redirect_PC=0x104.
REQ-038 Push 4 tags, 5th push with F_Valid -> Full=1, Count=4, 5th dropped; simultaneous pop+push while Full -> Count=3.
REQ-039 Mispredict with 3 younger tags queued plus same-edge push -> Count=0 after flush edge.
REQ-040 Rst asserted with pending mispredict pop -> next cycle Flush=0, WE=0, Count=0.
